// File: rtl/send_sched_if.sv
// Handshake bundle between the traffic scheduler and one send_module packet generator.
// master = scheduler side, slave = send_module side.
interface send_sched_if #(
    parameter int WIDTH_SEL      = 4,
    parameter int WIDTH_PRIORITY = 3,
    parameter int WIDTH_LENGTH   = 10
);
    logic                      start;
    logic                      single;
    logic                      ready;
    logic                      done;
    logic [WIDTH_SEL-1:0]      dest;
    logic [WIDTH_PRIORITY-1:0] prio;
    logic [WIDTH_LENGTH-1:0]   length;
    logic [19:0]               send_cycle;

    modport master (
        output start, single, dest, prio, length, send_cycle,
        input  ready, done
    );

    modport slave (
        input  start, single, dest, prio, length, send_cycle,
        output ready, done
    );
endinterface

// File: rtl/send_sched.sv
// Walks a table of traffic profiles and issues one send_module packet per start/done handshake.
// Optional watchdog on a stuck packet is enabled with SEND_SCHED_WDOG_EN.
module send_sched #(
    parameter int PROFILES       = 4,
    parameter int WIDTH_SEL      = 4,
    parameter int WIDTH_LENGTH   = 10,
    parameter int WIDTH_PRIORITY = 3,
    parameter int WDOG_CYCLES    = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [$clog2(PROFILES)-1:0] cfg_addr,
    input  logic [WIDTH_SEL-1:0]        cfg_dest,
    input  logic [WIDTH_PRIORITY-1:0]   cfg_priority,
    input  logic [WIDTH_LENGTH-1:0]     cfg_length,
    input  logic [19:0]                 cfg_gap,
    input  logic [7:0]                  cfg_count,
    input  logic                        run,
    input  logic                        loop,
    send_sched_if.master                tx,
    output logic                        busy,
    output logic [$clog2(PROFILES)-1:0] cur_profile,
    output logic [15:0]                 pkt_total,
    output logic                        sweep_done,
    output logic                        err_timeout
);
    localparam int AW = $clog2(PROFILES);
    localparam logic [AW-1:0] LAST_IDX = AW'(PROFILES - 1);

    typedef struct packed {
        logic [WIDTH_SEL-1:0]      dest;
        logic [WIDTH_PRIORITY-1:0] prio;
        logic [WIDTH_LENGTH-1:0]   length;
        logic [19:0]               gap;
        logic [7:0]                count;
    } prof_t;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, SEND, NEXT} state_t;

    state_t                    state_q, state_d;
    prof_t                     table_q [PROFILES];
    prof_t                     table_d [PROFILES];
    prof_t                     cur;
    logic [AW-1:0]             idx_q, idx_d;
    logic [7:0]                rem_q, rem_d;
    logic                      seen_q, seen_d;
    logic                      start_q, start_d;
    logic [WIDTH_SEL-1:0]      dest_q, dest_d;
    logic [WIDTH_PRIORITY-1:0] prio_q, prio_d;
    logic [WIDTH_LENGTH-1:0]   len_q, len_d;
    logic [19:0]               gap_q, gap_d;
    logic                      busy_q, busy_d;
    logic [15:0]               pkt_total_q, pkt_total_d;
    logic                      sweep_q, sweep_d;
`ifdef SEND_SCHED_WDOG_EN
    localparam logic [12:0] WD_LAST = 13'(WDOG_CYCLES - 1);
    logic [12:0]               wdog_q, wdog_d;
    logic                      err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        seen_d      = seen_q;
        start_d     = start_q;
        dest_d      = dest_q;
        prio_d      = prio_q;
        len_d       = len_q;
        gap_d       = gap_q;
        pkt_total_d = pkt_total_q;
        sweep_d     = 1'b0;
        cur         = table_q[idx_q];
`ifdef SEND_SCHED_WDOG_EN
        wdog_d      = wdog_q;
        err_d       = err_q;
`endif
        // LOAD reads table_q, so a same-cycle write to the active entry is seen next LOAD
        if (cfg_we) begin
            table_d[cfg_addr] = '{dest: cfg_dest, prio: cfg_priority, length: cfg_length,
                                  gap: cfg_gap, count: cfg_count};
        end

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            LOAD: begin
                if (cur.count == 8'd0) begin
                    state_d = NEXT;
                end else begin
                    dest_d  = cur.dest;
                    prio_d  = cur.prio;
                    len_d   = cur.length;
                    gap_d   = cur.gap;
                    rem_d   = cur.count;
                    seen_d  = 1'b1;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (tx.ready) begin
                    state_d = SEND;
`ifdef SEND_SCHED_WDOG_EN
                    wdog_d  = '0;
`endif
                end
            end
            SEND: begin
                // start rises one cycle into SEND; done is only honoured once start is high
                if (start_q && tx.done) begin
                    start_d = 1'b0;
                    rem_d   = rem_q - 8'd1;
                    if (pkt_total_q != 16'hFFFF) pkt_total_d = pkt_total_q + 16'd1;
                    if (!run)                   state_d = IDLE;
                    else if (rem_q == 8'd1)     state_d = NEXT;
                    else                        state_d = WAIT_RDY;
                end
`ifdef SEND_SCHED_WDOG_EN
                else if (wdog_q == WD_LAST) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = NEXT;
                end
`endif
                else begin
                    start_d = 1'b1;
`ifdef SEND_SCHED_WDOG_EN
                    wdog_d  = wdog_q + 13'd1;
`endif
                end
            end
            NEXT: begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + AW'(1);
                    state_d = LOAD;
                end else if (loop && seen_q) begin
                    idx_d   = '0;
                    seen_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    sweep_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            table_q     <= '{default: '0};
            idx_q       <= '0;
            rem_q       <= '0;
            seen_q      <= 1'b0;
            start_q     <= 1'b0;
            dest_q      <= '0;
            prio_q      <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            pkt_total_q <= '0;
            sweep_q     <= 1'b0;
`ifdef SEND_SCHED_WDOG_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            seen_q      <= seen_d;
            start_q     <= start_d;
            dest_q      <= dest_d;
            prio_q      <= prio_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            pkt_total_q <= pkt_total_d;
            sweep_q     <= sweep_d;
`ifdef SEND_SCHED_WDOG_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    assign tx.start      = start_q;
    assign tx.single     = 1'b1;
    assign tx.dest       = dest_q;
    assign tx.prio       = prio_q;
    assign tx.length     = len_q;
    assign tx.send_cycle = gap_q;
    assign busy          = busy_q;
    assign cur_profile   = idx_q;
    assign pkt_total     = pkt_total_q;
    assign sweep_done    = sweep_q;
`ifdef SEND_SCHED_WDOG_EN
    assign err_timeout   = err_q;
`else
    assign err_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_send_sched.sv
// Randomised bench for send_sched: a packet-list model built from the profile table is matched
// against every start pulse, with a send_module responder answering done after a set delay.
module tb_send_sched;
    localparam int P  = 4;
    localparam int WD = 16;

    logic        clk;
    logic        rst_n, cfg_we, run, loop;
    logic [1:0]  cfg_addr;
    logic [3:0]  cfg_dest;
    logic [2:0]  cfg_prio;
    logic [9:0]  cfg_length;
    logic [19:0] cfg_gap;
    logic [7:0]  cfg_count;
    logic        busy, sweep_done, err_timeout;
    logic [1:0]  cur_profile;
    logic [15:0] pkt_total;

    send_sched_if #(.WIDTH_SEL(4), .WIDTH_PRIORITY(3), .WIDTH_LENGTH(10)) tx_if ();

    send_sched #(.PROFILES(P), .WIDTH_SEL(4), .WIDTH_LENGTH(10), .WIDTH_PRIORITY(3),
                 .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dest(cfg_dest),
        .cfg_priority(cfg_prio), .cfg_length(cfg_length), .cfg_gap(cfg_gap),
        .cfg_count(cfg_count), .run(run), .loop(loop), .tx(tx_if), .busy(busy),
        .cur_profile(cur_profile), .pkt_total(pkt_total), .sweep_done(sweep_done),
        .err_timeout(err_timeout)
    );

    typedef struct {int dest; int prio; int len; int gap; int cnt;} prof_t;
    typedef struct {int prof; int dest; int prio; int len; int gap;} pkt_t;

    prof_t tbl [P];
    pkt_t  exp_q [$];
    pkt_t  e;
    int    total, bad;
    int    exp_pkts, n_start, n_sweep, done_dly;
    int    gap_cyc, last_prof;
    bit    resp_en, stray_en, chk_gap, gap_arm;
    logic  prev_start;
    logic [3:0] held_dest;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // send_module stand-in: done pulses done_dly cycles after start is seen; optional stray dones
    initial begin
        int cnt;
        cnt = 0;
        tx_if.done = 1'b0;
        forever begin
            @(negedge clk);
            tx_if.done = 1'b0;
            if (tx_if.start === 1'b1 && resp_en) begin
                cnt++;
                if (cnt >= done_dly) begin
                    tx_if.done = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (stray_en && $urandom_range(0, 3) == 0) tx_if.done = 1'b1;
            end
        end
    end

    // Monitor: every rising start is matched against the head of the expected packet list
    initial begin
        prev_start = 1'b0;
        gap_arm = 1'b0;
        last_prof = -1;
        forever begin
            @(negedge clk);
            if (gap_arm) gap_cyc++;
            if (rst_n === 1'b1 && tx_if.start === 1'b1 && prev_start !== 1'b1) begin
                n_start++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dest", tx_if.dest, e.dest);
                    chk("prio", tx_if.prio, e.prio);
                    chk("length", tx_if.length, e.len);
                    chk("send_cycle", tx_if.send_cycle, e.gap);
                    chk("cur_profile", cur_profile, e.prof);
                    chk("single", tx_if.single, 1);
                    if (gap_arm && chk_gap && e.prof == last_prof) chk("restart_gap", gap_cyc, 3);
                    last_prof = e.prof;
                end
                held_dest = tx_if.dest;
                gap_arm = 1'b0;
            end else if (tx_if.start === 1'b1) begin
                chk("dest_stable", tx_if.dest, held_dest);
            end
            if (tx_if.start === 1'b1 && tx_if.done === 1'b1) begin
                gap_arm = 1'b1;
                gap_cyc = 0;
            end
            if (sweep_done === 1'b1) begin
                n_sweep++;
                gap_arm = 1'b0;
            end
            prev_start = tx_if.start;
        end
    end

    task automatic wr(input int a, input int d, input int pr, input int l, input int g, input int c);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_dest = 4'(d); cfg_prio = 3'(pr);
        cfg_length = 10'(l); cfg_gap = 20'(g); cfg_count = 8'(c);
        @(negedge clk);
        cfg_we = 1'b0;
        tbl[a] = '{d, pr, l, g, c};
    endtask

    task automatic build_sweep();
        for (int p = 0; p < P; p++)
            for (int k = 0; k < tbl[p].cnt; k++) begin
                exp_q.push_back('{p, tbl[p].dest, tbl[p].prio, tbl[p].len, tbl[p].gap});
                exp_pkts++;
            end
    endtask

    task automatic wait_sweep(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sweep_done === 1'b1) break;
        end
        run = 1'b0;
        chk({tag, "_sweep_seen"}, (i < budget), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"}, tx_if.start, 0);
        chk({tag, "_single"}, tx_if.single, 1);
        chk({tag, "_dest"}, tx_if.dest, 0);
        chk({tag, "_prio"}, tx_if.prio, 0);
        chk({tag, "_length"}, tx_if.length, 0);
        chk({tag, "_send_cycle"}, tx_if.send_cycle, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cur_profile"}, cur_profile, 0);
        chk({tag, "_pkt_total"}, pkt_total, 0);
        chk({tag, "_sweep_done"}, sweep_done, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    initial begin
        int lat, s0, w0, hi, i;
        total = 0; bad = 0; exp_pkts = 0; n_start = 0; n_sweep = 0;
        done_dly = 5; resp_en = 1'b1; stray_en = 1'b0; chk_gap = 1'b1;
        rst_n = 1'b0; cfg_we = 1'b0; run = 1'b0; loop = 1'b0; tx_if.ready = 1'b1;
        cfg_addr = '0; cfg_dest = '0; cfg_prio = '0; cfg_length = '0; cfg_gap = '0; cfg_count = '0;
        for (int p = 0; p < P; p++) tbl[p] = '{0, 0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Basic: one profile of three packets, exact start latency
        wr(0, 2, 2, 10, 20, 3);
        build_sweep();
        s0 = n_start; w0 = n_sweep;
        run = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (tx_if.start !== 1'b1 && lat < 20);
        chk("start_latency", lat, 4);
        wait_sweep("basic", 300);
        chk("basic_busy", busy, 0);
        chk("basic_pkt_total", pkt_total, exp_pkts);
        chk("basic_starts", n_start - s0, 3);
        @(negedge clk);
        chk("basic_sweeps", n_sweep - w0, 1);
        chk("basic_list_empty", exp_q.size(), 0);

        // Random tables, random done delay, stray done pulses while start is low
        stray_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            for (int p = 0; p < P; p++)
                wr(p, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1023),
                   $urandom_range(0, 20'hFFFFF), (p == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3));
            done_dly = $urandom_range(1, 6);
            build_sweep();
            run = 1'b1;
            wait_sweep("rand", 1500);
            @(negedge clk);
            chk("rand_pkt_total", pkt_total, exp_pkts);
            chk("rand_list_empty", exp_q.size(), 0);
        end
        stray_en = 1'b0;
        done_dly = 5;

        // Empty table: a sweep with no starts that still ends
        for (int p = 0; p < P; p++) wr(p, 1, 1, 1, 1, 0);
        s0 = n_start;
        run = 1'b1;
        wait_sweep("empty", 30);
        @(negedge clk);
        chk("empty_starts", n_start - s0, 0);
        chk("empty_busy", busy, 0);

        // Loop, then drop run while the third packet is in flight
        chk_gap = 1'b0;
        wr(0, 6, 3, 64, 7, 1);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{0, 6, 3, 64, 7});
            exp_pkts++;
        end
        s0 = n_start; w0 = n_sweep;
        loop = 1'b1; run = 1'b1;
        for (i = 0; i < 400 && (n_start - s0) < 3; i++) @(negedge clk);
        chk("loop_three_starts", (n_start - s0), 3);
        run = 1'b0;
        for (i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk);
        chk("stop_idle", busy, 0);
        chk("stop_pkt_total", pkt_total, exp_pkts);
        repeat (30) @(negedge clk);
        chk("stop_no_more_starts", n_start - s0, 3);
        chk("loop_no_sweep_done", n_sweep - w0, 0);
        loop = 1'b0;

        // Backpressure, then reset in the middle of a packet
        wr(0, 11, 5, 100, 9, 2);
        build_sweep();
        s0 = n_start;
        tx_if.ready = 1'b0;
        run = 1'b1;
        hi = 0;
        repeat (30) begin @(negedge clk); if (tx_if.start === 1'b1) hi++; end
        chk("backpressure_start_low", hi, 0);
        tx_if.ready = 1'b1;
        for (i = 0; i < 100 && (n_start - s0) < 2; i++) @(negedge clk);
        chk("bp_second_start", n_start - s0, 2);
        chk("bp_start_high", tx_if.start, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        rst_n = 1'b1;
        for (int p = 0; p < P; p++) tbl[p] = '{0, 0, 0, 0, 0};
        exp_q.delete();
        exp_pkts = 0;
        s0 = n_start;
        wait_sweep("post_rst", 30);
        chk("post_rst_no_start", n_start - s0, 0);

`ifdef SEND_SCHED_WDOG_EN
        // Watchdog: send_module never answers, both profiles time out in turn
        resp_en = 1'b0;
        wr(0, 5, 1, 7, 3, 2);
        wr(1, 9, 2, 8, 4, 1);
        exp_q.push_back('{0, 5, 1, 7, 3});
        exp_q.push_back('{1, 9, 2, 8, 4});
        run = 1'b1;
        wait_sweep("wdog", 300);
        chk("wdog_err", err_timeout, 1);
        chk("wdog_pkt_total", pkt_total, 0);
        chk("wdog_next_profile_loaded", exp_q.size(), 0);
        resp_en = 1'b1;
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
